// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage stall, bubble and flush control with a long-latency op scoreboard.
module hazard_unit #(
  parameter int MAX_LONG = 2,
  parameter int CNT_W = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            id_valid,
  input  logic [4:0]                      id_rs1,
  input  logic [4:0]                      id_rs2,
  input  logic                            id_uses_rs1,
  input  logic                            id_uses_rs2,
  input  logic [4:0]                      id_rd,
  input  logic                            id_reg_write,
  input  logic                            id_is_long,
  input  logic [4:0]                      id_ex_rd,
  input  logic                            id_ex_mem_read,
  input  logic                            ex_branch_taken,
  input  logic                            long_wb_valid,
  input  logic [4:0]                      long_wb_rd,
  output logic                            stall_pc,
  output logic                            stall_if_id,
  output logic                            bubble_id_ex,
  output logic                            flush_if_id,
  output logic                            issue,
  output logic [$clog2(MAX_LONG+1)-1:0]   long_outstanding,
  output logic [CNT_W-1:0]                stall_cycles,
  output logic                            err_underflow
);
  localparam int OW = $clog2(MAX_LONG+1);
  logic [31:0]      pending_q, pending_d;
  logic [OW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             err_q, err_d;
  logic             load_use, raw, waw, structural, hazard, inc, wb_ok;
  // A same-cycle writeback is visible through the write-through register file.
  function automatic logic busy(input logic [4:0] r);
    return pending_q[r] && !(long_wb_valid && long_wb_rd == r);
  endfunction
  assign load_use   = id_ex_mem_read && id_ex_rd != 5'd0 &&
                      ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
  assign raw        = (id_uses_rs1 && busy(id_rs1)) || (id_uses_rs2 && busy(id_rs2));
  assign waw        = id_reg_write && id_rd != 5'd0 && busy(id_rd);
  assign structural = id_is_long && cnt_q == OW'(MAX_LONG) && !long_wb_valid;
  assign hazard     = id_valid && (load_use || raw || waw || structural);
  assign flush_if_id  = ex_branch_taken;
  assign bubble_id_ex = ex_branch_taken || hazard;
  assign stall_pc     = !ex_branch_taken && hazard;
  assign stall_if_id  = stall_pc;
  assign issue        = id_valid && !ex_branch_taken && !hazard;
  assign inc   = issue && id_is_long;
  assign wb_ok = long_wb_valid && cnt_q != '0;
  always_comb begin
    pending_d = pending_q;
    if (wb_ok) pending_d[long_wb_rd] = 1'b0;
    if (inc && id_reg_write && id_rd != 5'd0) pending_d[id_rd] = 1'b1;
    pending_d[0] = 1'b0;
    cnt_d   = (inc && !long_wb_valid) ? cnt_q + OW'(1) : (wb_ok && !inc) ? cnt_q - OW'(1) : cnt_q;
    stall_d = stall_q + CNT_W'(stall_pc && !(&stall_q));
    err_d   = err_q || (long_wb_valid && cnt_q == '0);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      stall_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
    end
  end
  assign long_outstanding = cnt_q;
  assign stall_cycles     = stall_q;
  assign err_underflow    = err_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios checked against a bench-side scoreboard model every cycle.
module tb_hazard_unit;
  localparam int MAXL = 2;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n;
  logic idv, u1, u2, rw, lng, exld, br, wbv;
  logic [4:0] rs1, rs2, rd, exrd, wbrd;
  logic stall_pc, stall_if_id, bubble_id_ex, flush_if_id, issue, err_underflow;
  logic [$clog2(MAXL+1)-1:0] long_outstanding;
  logic [CW-1:0] stall_cycles;
  int n_cmp = 0, n_bad = 0;
  bit pend_m[32];
  int cnt_m = 0, stall_m = 0;
  bit err_m = 0;

  hazard_unit #(.MAX_LONG(MAXL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(idv), .id_rs1(rs1), .id_rs2(rs2),
    .id_uses_rs1(u1), .id_uses_rs2(u2), .id_rd(rd), .id_reg_write(rw), .id_is_long(lng),
    .id_ex_rd(exrd), .id_ex_mem_read(exld), .ex_branch_taken(br),
    .long_wb_valid(wbv), .long_wb_rd(wbrd), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id), .issue(issue),
    .long_outstanding(long_outstanding), .stall_cycles(stall_cycles), .err_underflow(err_underflow));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // A register still waits on its long result unless this cycle's writeback delivers it.
  function automatic bit waiting(input int r);
    return pend_m[r] && !(wbv && int'(wbrd) == r);
  endfunction

  function automatic bit m_hazard();
    bit lu, st;
    lu = exld && exrd != 0 && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
    st = lng && cnt_m == MAXL && !wbv;
    return idv && (lu || (u1 && waiting(rs1)) || (u2 && waiting(rs2)) ||
                   (rw && rd != 0 && waiting(rd)) || st);
  endfunction

  initial begin
    bit hz, iss;
    forever begin
      @(negedge clk);
      hz  = m_hazard();
      iss = idv && !br && !hz;
      chk("flush_if_id", flush_if_id, br);
      chk("bubble_id_ex", bubble_id_ex, br || hz);
      chk("stall_pc", stall_pc, !br && hz);
      chk("stall_if_id", stall_if_id, !br && hz);
      chk("issue", issue, iss);
      chk("long_outstanding", int'(long_outstanding), cnt_m);
      chk("stall_cycles", int'(stall_cycles), stall_m);
      chk("err_underflow", err_underflow, err_m);
      if (!rst_n) begin
        foreach (pend_m[i]) pend_m[i] = 0;
        cnt_m = 0; stall_m = 0; err_m = 0;
      end else begin
        if (!br && hz && stall_m < SAT) stall_m++;
        if (wbv && cnt_m == 0) err_m = 1;
        else if (wbv) pend_m[wbrd] = 0;
        if (iss && lng && rw && rd != 0) pend_m[rd] = 1;
        if (iss && lng && !wbv) cnt_m++;
        else if (!(iss && lng) && wbv && cnt_m > 0) cnt_m--;
      end
    end
  end

  task automatic clr();
    {idv, u1, u2, rw, lng, exld, br, wbv} = '0;
    {rs1, rs2, rd, exrd, wbrd} = '0;
  endtask

  task automatic nx();
    @(posedge clk);
    #1 clr();
  endtask

  task automatic id(input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub,
                    input logic [4:0] d, input logic w, input logic l);
    idv = 1; rs1 = a; u1 = ua; rs2 = b; u2 = ub; rd = d; rw = w; lng = l;
  endtask

  initial begin
    rst_n = 0; clr();
    nx(); nx();
    rst_n = 1;
    #2 chk("reset stall_cycles", int'(stall_cycles), 0);
    chk("reset outstanding", int'(long_outstanding), 0);
    chk("reset err", err_underflow, 0);
    // load-use
    nx(); exld = 1; exrd = 5; id(5, 1, 0, 0, 6, 1, 0);
    #2 chk("lu stall", stall_pc, 1);
    chk("lu bubble", bubble_id_ex, 1);
    chk("lu issue", issue, 0);
    nx(); id(5, 1, 0, 0, 6, 1, 0);
    #2 chk("lu release", issue, 1);
    chk("lu stall_cycles", int'(stall_cycles), 1);
    nx(); exld = 1; exrd = 0; id(0, 1, 0, 0, 6, 1, 0);
    #2 chk("lu rd0", issue, 1);
    nx(); exld = 1; exrd = 5; id(5, 0, 0, 0, 6, 1, 0);
    #2 chk("lu unused", issue, 1);
    nx(); exld = 1; exrd = 5; id(1, 1, 5, 1, 6, 1, 0);
    #2 chk("lu rs2", stall_pc, 1);
    // long RAW with a stall long enough to saturate the counter
    nx(); id(0, 0, 0, 0, 7, 1, 1);
    #2 chk("div issue", issue, 1);
    for (int i = 0; i < 20; i++) begin
      nx(); id(7, 1, 0, 0, 1, 1, 0);
    end
    #2 chk("raw stall", stall_pc, 1);
    chk("raw count", int'(long_outstanding), 1);
    chk("stall saturate", int'(stall_cycles), SAT);
    nx(); id(7, 1, 0, 0, 1, 1, 0); wbv = 1; wbrd = 7;
    #2 chk("raw release", issue, 1);
    nx();
    nx(); id(7, 1, 0, 0, 1, 1, 0);
    #2 chk("raw cleared", issue, 1);
    chk("raw drained", int'(long_outstanding), 0);
    // structural limit
    nx(); id(0, 0, 0, 0, 3, 1, 1);
    nx(); id(0, 0, 0, 0, 4, 1, 1);
    nx(); id(0, 0, 0, 0, 10, 1, 1);
    #2 chk("struct full", int'(long_outstanding), 2);
    chk("struct stall", stall_pc, 1);
    nx(); id(0, 0, 0, 0, 10, 1, 1); wbv = 1; wbrd = 3;
    #2 chk("struct release", issue, 1);
    nx();
    #2 chk("struct count", int'(long_outstanding), 2);
    nx(); wbv = 1; wbrd = 4;
    nx(); wbv = 1; wbrd = 10;
    // WAW and same-cycle set/clear
    nx(); id(0, 0, 0, 0, 9, 1, 1);
    nx(); id(1, 1, 0, 0, 9, 1, 0);
    #2 chk("waw stall", stall_pc, 1);
    nx(); id(0, 0, 0, 0, 9, 1, 1); wbv = 1; wbrd = 9;
    #2 chk("waw setclr issue", issue, 1);
    nx();
    #2 chk("waw count", int'(long_outstanding), 1);
    nx(); id(9, 1, 0, 0, 1, 1, 0);
    #2 chk("x9 still pending", stall_pc, 1);
    nx(); wbv = 1; wbrd = 9;
    // flush priority
    nx(); exld = 1; exrd = 5; br = 1; id(5, 1, 0, 0, 6, 1, 0);
    #2 chk("flush flush", flush_if_id, 1);
    chk("flush bubble", bubble_id_ex, 1);
    chk("flush stall", stall_pc, 0);
    chk("flush issue", issue, 0);
    nx(); br = 1; id(0, 0, 0, 0, 6, 1, 1);
    #2 chk("flush long issue", issue, 0);
    nx();
    #2 chk("flush count", int'(long_outstanding), 0);
    // underflow and reset
    nx(); wbv = 1; wbrd = 2;
    nx();
    #2 chk("underflow err", err_underflow, 1);
    chk("underflow count", int'(long_outstanding), 0);
    nx(); id(0, 0, 0, 0, 2, 1, 1);
    nx(); id(2, 1, 0, 0, 1, 1, 0);
    #2 chk("x2 pending", stall_pc, 1);
    nx(); rst_n = 0;
    nx(); rst_n = 1; id(2, 1, 0, 0, 1, 1, 0);
    #2 chk("post reset issue", issue, 1);
    chk("post reset count", int'(long_outstanding), 0);
    chk("post reset err", err_underflow, 0);
    chk("post reset stalls", int'(stall_cycles), 0);
    nx(); nx();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
